// File: rtl/cpu_pkg.sv
// Shared definitions for the microprocessor datapath blocks: default
// widths, the fetch NOP word and the fetch-handshake state encoding.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 8;
    localparam int CPU_INSTR_W = 16;

    localparam logic [CPU_INSTR_W-1:0] CPU_NOP_WORD = '0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-pc selection (sequential step, branch redirect,
// natural wrap at 2^ADDR_W) and a pending-update slot used to defer a PC
// advance that arrives while an instruction read is still outstanding.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_enable,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              in_wait,
    input  logic              complete,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_update
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] target;

    // Candidate new PC for this cycle; the adder truncates so the PC wraps.
    always_comb begin
        target = branch_taken ? branch_target : pc_q + ADDR_W'(PC_STEP);
    end

    // Apply updates immediately in IDLE; in WAIT park them until the read ends.
    always_comb begin
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        pc_update    = 1'b0;
        if (!in_wait) begin
            if (pc_enable) begin
                pc_d      = target;
                pc_update = 1'b1;
            end
        end else if (complete) begin
            pend_valid_d = 1'b0;
            if (pc_enable) begin
                pc_d      = target;
                pc_update = 1'b1;
            end else if (pend_valid_q) begin
                pc_d      = pend_q;
                pc_update = 1'b1;
            end
        end else if (pc_enable) begin
            pend_d       = target;
            pend_valid_d = 1'b1;
        end
    end

    // PC and pending-slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= ADDR_W'(RESET_PC);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch responder for the control-unit sequencer: issues the
// instruction-memory read on load_enable, waits for the ack with a bounded
// timeout, latches the instruction register and reports busy/error status.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                  ADDR_W   = CPU_ADDR_W,
    parameter int                  INSTR_W  = CPU_INSTR_W,
    parameter int                  RESET_PC = 0,
    parameter int                  PC_STEP  = 1,
    parameter int                  TIMEOUT  = 15,
    parameter logic [INSTR_W-1:0]  NOP_WORD = INSTR_W'(CPU_NOP_WORD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_enable,
    input  logic               pc_enable,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               fetch_busy,
    output logic               fetch_err
);

    fetch_state_e       state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               busy_q, busy_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [7:0]         cnt_q, cnt_d;

    logic               timeout_hit;
    logic               read_done;
    logic [ADDR_W-1:0]  pc_next;
    logic               pc_update;

    // The last counted WAIT cycle without an ack aborts the read.
    always_comb begin
        timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
        read_done   = (state_q == WAIT) && (imem_ack || timeout_hit);
    end

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .pc_enable     (pc_enable),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .in_wait       (state_q == WAIT),
        .complete      (read_done),
        .pc            (pc),
        .pc_next       (pc_next),
        .pc_update     (pc_update)
    );

    // Handshake FSM: issue from IDLE, then finish on ack (preferred) or timeout.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pc_update) begin
                    valid_d = 1'b0;
                end
                if (load_enable) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = pc_next;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    instr_d = imem_rdata;
                    valid_d = !pc_update;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    instr_d = NOP_WORD;
                    valid_d = !pc_update;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs and FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign fetch_busy  = busy_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch rules.
module tb_fetch_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_enable = 1'b0;
    logic        pc_enable = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_err;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic        m_valid;
    logic        m_busy;
    logic [7:0]  m_addr;
    logic        m_err;
    int          m_waited;
    logic        m_pend_has;
    logic [7:0]  m_pend;

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (0),
        .PC_STEP  (1),
        .TIMEOUT  (TO),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_enable   (load_enable),
        .pc_enable     (pc_enable),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .fetch_busy    (fetch_busy),
        .fetch_err     (fetch_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the model, expressed as fetch transactions rather than states.
    task automatic modelStep();
        logic [7:0] tgt;
        logic       done;
        if (reset) begin
            m_pc = 8'h00; m_instr = '0; m_valid = 0; m_busy = 0; m_addr = 8'h00;
            m_err = 0; m_waited = 0; m_pend_has = 0; m_pend = '0;
            return;
        end
        tgt = branch_taken ? branch_target : 8'(m_pc + 8'd1);
        if (!m_busy) begin
            if (pc_enable) begin
                m_pc = tgt;
                m_valid = 0;
            end
            if (load_enable) begin
                m_busy = 1; m_addr = m_pc; m_valid = 0; m_waited = 0;
            end
        end else begin
            m_waited++;
            done = imem_ack || (m_waited == TO);
            if (pc_enable) begin
                m_pend_has = 1; m_pend = tgt;
            end
            if (done) begin
                m_busy = 0;
                m_instr = imem_ack ? imem_rdata : 16'h0000;
                if (!imem_ack) m_err = 1;
                if (m_pend_has) begin
                    m_pc = m_pend; m_valid = 0; m_pend_has = 0;
                end else begin
                    m_valid = 1;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("pc", 32'(pc), 32'(m_pc));
        checkOutput("instr", 32'(instr), 32'(m_instr));
        checkOutput("instr_valid", 32'(instr_valid), 32'(m_valid));
        checkOutput("imem_req", 32'(imem_req), 32'(m_busy));
        checkOutput("fetch_busy", 32'(fetch_busy), 32'(m_busy));
        checkOutput("fetch_err", 32'(fetch_err), 32'(m_err));
        if (m_busy) checkOutput("imem_addr", 32'(imem_addr), 32'(m_addr));
    endtask

    // Drive one cycle of inputs, clock it, advance the model, compare.
    task automatic applyStimulus(input logic r, input logic le, input logic pe, input logic bt,
                                 input logic [7:0] tgt, input logic ack, input logic [15:0] rd);
        reset = r; load_enable = le; pc_enable = pe; branch_taken = bt;
        branch_target = tgt; imem_ack = ack; imem_rdata = rd;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        // Reset
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 16'h0);
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 16'h0);
        checkOutput("rst_pc", 32'(pc), 32'h00);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'h00);
        checkOutput("rst_valid", 32'(instr_valid), 32'h0);
        $display("[TB] reset done");

        // Basic fetch, ack one cycle after request
        applyStimulus(0, 1, 0, 0, 8'h00, 0, 16'h0);
        checkOutput("fetch_req", 32'(imem_req), 32'h1);
        checkOutput("fetch_addr", 32'(imem_addr), 32'h00);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 16'hA5C3);
        checkOutput("fetch_instr", 32'(instr), 32'hA5C3);
        checkOutput("fetch_valid", 32'(instr_valid), 32'h1);
        checkOutput("fetch_busy_low", 32'(fetch_busy), 32'h0);

        // PC sequencing: branch to 10, step, branch to 40, branch to FF, wrap
        applyStimulus(0, 0, 1, 1, 8'h10, 0, 16'h0);
        checkOutput("pc_valid_clr", 32'(instr_valid), 32'h0);
        applyStimulus(0, 0, 1, 0, 8'h77, 0, 16'h0);
        checkOutput("pc_step", 32'(pc), 32'h11);
        applyStimulus(0, 0, 1, 1, 8'h40, 0, 16'h0);
        checkOutput("pc_branch", 32'(pc), 32'h40);
        applyStimulus(0, 0, 1, 1, 8'hFF, 0, 16'h0);
        applyStimulus(0, 0, 1, 0, 8'h00, 0, 16'h0);
        checkOutput("pc_wrap", 32'(pc), 32'h00);

        // Timeout: memory never acks
        applyStimulus(0, 1, 0, 0, 8'h00, 0, 16'h0);
        for (int i = 1; i < TO; i++) applyStimulus(0, 0, 0, 0, 8'h00, 0, 16'h0);
        checkOutput("to_still_busy", 32'(fetch_busy), 32'h1);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 16'h0);
        checkOutput("to_instr_nop", 32'(instr), 32'h0000);
        checkOutput("to_valid", 32'(instr_valid), 32'h1);
        checkOutput("to_err", 32'(fetch_err), 32'h1);
        applyStimulus(0, 1, 0, 0, 8'h00, 0, 16'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 16'h1234);
        checkOutput("to_err_sticky", 32'(fetch_err), 32'h1);

        // Deferred pc_enable inside WAIT
        applyStimulus(0, 1, 0, 0, 8'h00, 0, 16'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 16'h0);
        applyStimulus(0, 0, 1, 0, 8'h00, 0, 16'h0);
        checkOutput("defer_pc_hold", 32'(pc), 32'h00);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 16'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 16'h0);
        checkOutput("defer_addr", 32'(imem_addr), 32'h00);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 16'hBEEF);
        checkOutput("defer_pc_applied", 32'(pc), 32'h01);
        checkOutput("defer_valid0", 32'(instr_valid), 32'h0);

        // load_enable and pc_enable together in IDLE
        applyStimulus(0, 0, 1, 1, 8'h20, 0, 16'h0);
        applyStimulus(0, 1, 1, 0, 8'h00, 0, 16'h0);
        checkOutput("both_addr", 32'(imem_addr), 32'h21);
        checkOutput("both_pc", 32'(pc), 32'h21);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 16'h5A5A);

        // Reset during WAIT, then a late ack
        applyStimulus(0, 1, 0, 0, 8'h00, 0, 16'h0);
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 16'h0);
        checkOutput("rstw_req", 32'(imem_req), 32'h0);
        checkOutput("rstw_pc", 32'(pc), 32'h00);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 16'hDEAD);
        checkOutput("rstw_late_ack", 32'(instr_valid), 32'h0);
        checkOutput("rstw_instr", 32'(instr), 32'h0000);

        // Random traffic: responsive memory, then a sluggish one to reach timeouts
        for (int i = 0; i < 600; i++) begin
            automatic int ack_pct = (i < 300) ? 40 : 4;
            automatic logic r  = ($urandom_range(0, 199) == 0);
            automatic logic le = ($urandom_range(0, 99) < 35);
            automatic logic pe = ($urandom_range(0, 99) < 20);
            automatic logic bt = $urandom_range(0, 1) == 1;
            automatic logic [7:0] tg = 8'($urandom);
            automatic logic ak = m_busy ? ($urandom_range(0, 99) < ack_pct)
                                        : ($urandom_range(0, 99) < 5);
            automatic logic [15:0] rd = 16'($urandom);
            applyStimulus(r, le, pe, bt, tg, ak, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
